mem2stream_apb_csr: RTL and testbench

APB completer holding the control/status registers of the AXI memory-to-stream DMA core. Decodes the CSR map (VERSION, CONTROL, START/END region, NUM, CNT), drives level-mode control signals into the DMA engine, and tracks single and continuous transfer completion, clearing GO and raising an interrupt when a job finishes. Sits between the system APB bus and the mem2stream datapath, on the PCLK domain.

---
 rtl/mem2stream_apb_csr.sv | 217 +++++++++++++++++++++
 tb/tb_mem2stream_apb_csr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem2stream_apb_csr.sv
// mem2stream_apb_csr
//   APB completer holding the control/status registers of the AXI
//   memory-to-stream DMA core. Drives level-mode control into the DMA engine
//   and tracks single/continuous job completion (GO clear + interrupt).
//
// Ports
//   PCLK, PRESETn          clock, synchronous active-low reset
//   PSEL..PPROT            APB completer inputs (PPROT ignored)
//   PRDATA, PREADY, PSLVERR APB completer outputs (zero wait states)
//   IRQ                    CONTROL.IP & CONTROL.IE
//   dma_en/go/cont/chunk/num/start/end  level controls to the engine
//   dma_abort              one-cycle stop request to the engine
//   dma_done               one-cycle pulse per finished region pass
//
// Register map (PADDR[7:0])
//   0x00 VERSION (RO)    0x10 CONTROL {EN[31], IP[1] W1C, IE[0]}
//   0x20 START0  0x24 START1  0x28 END0  0x2C END1
//   0x30 NUM {GO[31], CONT[28], CHUNK[23:16], NUM_BYTE[15:0]}
//   0x40 CNT (remaining continuous passes)
//
// Build option
//   MEM2STREAM_CSR_ADDR64_EN : makes START1/END1 real registers driving the
//   upper 32 bits of dma_start/dma_end. Without it they read 0 and ignore
//   writes.

module mem2stream_apb_csr #(
  parameter int unsigned APB_AW  = 32,
  parameter int unsigned APB_DW  = 32,
  parameter logic [31:0] VERSION = 32'h2019_0405
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PWRITE,
  input  logic [APB_DW-1:0] PWDATA,
  input  logic [3:0]        PSTRB,
  input  logic [2:0]        PPROT,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              IRQ,
  output logic              dma_en,
  output logic              dma_go,
  output logic              dma_cont,
  output logic [7:0]        dma_chunk,
  output logic [15:0]       dma_num,
  output logic [63:0]       dma_start,
  output logic [63:0]       dma_end,
  output logic              dma_abort,
  input  logic              dma_done
);

  localparam logic [7:0] OFF_VERSION = 8'h00;
  localparam logic [7:0] OFF_CONTROL = 8'h10;
  localparam logic [7:0] OFF_START0  = 8'h20;
  localparam logic [7:0] OFF_START1  = 8'h24;
  localparam logic [7:0] OFF_END0    = 8'h28;
  localparam logic [7:0] OFF_END1    = 8'h2C;
  localparam logic [7:0] OFF_NUM     = 8'h30;
  localparam logic [7:0] OFF_CNT     = 8'h40;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] wr_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wr_v[8*b +: 8];
    end
    return res;
  endfunction

  // Register state
  logic        ctrl_en, ctrl_ip, ctrl_ie;
  logic [31:0] start0, end0;
  logic [31:0] start1, end1;
  logic        num_go, num_cont;
  logic [7:0]  num_chunk;
  logic [15:0] num_byte;
  logic [31:0] cnt;
  logic [31:0] prdata_r;
  logic        abort_r;

  logic [7:0]  addr;
  logic        rd_setup, wr_setup, wr_acc, addr_ok;
  logic [31:0] ctrl_rd, num_rd, rd_mux;
  logic [31:0] ctrl_new, num_new;
  logic        ctrl_wr, num_wr, cnt_wr, ip_w1c;
  logic        num_start, num_reject, num_stop, en_stop, abort;
  logic        done_hit, finish;

  assign addr     = PADDR[7:0];
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;
  assign wr_setup = PSEL & ~PENABLE & PWRITE;
  assign wr_acc   = PSEL & PENABLE & PWRITE;

  assign ctrl_rd = {ctrl_en, 29'b0, ctrl_ip, ctrl_ie};
  assign num_rd  = {num_go, 2'b0, num_cont, 4'b0, num_chunk, num_byte};

  always_comb begin
    addr_ok = 1'b1;
    rd_mux  = 32'h0;
    case (addr)
      OFF_VERSION: rd_mux = VERSION;
      OFF_CONTROL: rd_mux = ctrl_rd;
      OFF_START0:  rd_mux = start0;
      OFF_START1:  rd_mux = start1;
      OFF_END0:    rd_mux = end0;
      OFF_END1:    rd_mux = end1;
      OFF_NUM:     rd_mux = num_rd;
      OFF_CNT:     rd_mux = cnt;
      default:     addr_ok = 1'b0;
    endcase
  end

  assign ctrl_wr  = wr_acc & (addr == OFF_CONTROL);
  assign num_wr   = wr_acc & (addr == OFF_NUM);
  assign cnt_wr   = wr_acc & (addr == OFF_CNT);
  assign ctrl_new = merge_be(ctrl_rd, PWDATA, PSTRB);
  assign num_new  = merge_be(num_rd, PWDATA, PSTRB);
  assign ip_w1c   = ctrl_wr & PSTRB[0] & PWDATA[1];

  // A GO=1 write only launches an idle, enabled engine; otherwise it is refused.
  assign num_reject = num_wr & num_new[31] & (~ctrl_en | num_go);
  assign num_start  = num_wr & num_new[31] & ctrl_en & ~num_go;
  assign num_stop   = num_wr & ~num_new[31] & num_go;
  assign en_stop    = ctrl_wr & ~ctrl_new[31] & num_go;
  assign abort      = num_stop | en_stop;

  // The abort path takes precedence over a coincident completion.
  assign done_hit = dma_done & num_go & ~abort;
  assign finish   = done_hit & (~num_cont | (cnt <= 32'd1));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ctrl_en   <= 1'b0;
      ctrl_ip   <= 1'b0;
      ctrl_ie   <= 1'b0;
      start0    <= 32'h0;
      end0      <= 32'h0;
      num_go    <= 1'b0;
      num_cont  <= 1'b0;
      num_chunk <= 8'h0;
      num_byte  <= 16'h0;
      cnt       <= 32'h0;
      prdata_r  <= 32'h0;
      abort_r   <= 1'b0;
    end else begin
      abort_r <= abort;

      if (rd_setup)      prdata_r <= rd_mux;
      else if (wr_setup) prdata_r <= 32'h0;

      if (ctrl_wr) begin
        ctrl_en <= ctrl_new[31];
        ctrl_ie <= ctrl_new[0];
      end
      // Completion set beats a simultaneous W1C.
      if (finish)      ctrl_ip <= 1'b1;
      else if (ip_w1c) ctrl_ip <= 1'b0;

      if (wr_acc && addr == OFF_START0) start0 <= merge_be(start0, PWDATA, PSTRB);
      if (wr_acc && addr == OFF_END0)   end0   <= merge_be(end0, PWDATA, PSTRB);

      if (num_wr && !num_reject) begin
        num_cont  <= num_new[28];
        num_chunk <= num_new[23:16];
        num_byte  <= num_new[15:0];
      end
      if (num_start)            num_go <= 1'b1;
      else if (abort || finish) num_go <= 1'b0;

      // CPU write beats the pass decrement; a zero count runs one pass.
      if (cnt_wr)
        cnt <= merge_be(cnt, PWDATA, PSTRB);
      else if (num_start && num_new[28] && cnt == 32'h0)
        cnt <= 32'd1;
      else if (done_hit && num_cont)
        cnt <= (cnt == 32'h0) ? 32'h0 : cnt - 32'd1;
    end
  end

`ifdef MEM2STREAM_CSR_ADDR64_EN
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      start1 <= 32'h0;
      end1   <= 32'h0;
    end else begin
      if (wr_acc && addr == OFF_START1) start1 <= merge_be(start1, PWDATA, PSTRB);
      if (wr_acc && addr == OFF_END1)   end1   <= merge_be(end1, PWDATA, PSTRB);
    end
  end
`else
  assign start1 = 32'h0;
  assign end1   = 32'h0;
`endif

  assign PRDATA    = prdata_r;
  assign PREADY    = 1'b1;
  assign PSLVERR   = PSEL & PENABLE & (~addr_ok | num_reject);
  assign IRQ       = ctrl_ip & ctrl_ie;
  assign dma_en    = ctrl_en;
  assign dma_go    = num_go;
  assign dma_cont  = num_cont;
  assign dma_chunk = num_chunk;
  assign dma_num   = num_byte;
  assign dma_start = {start1, start0};
  assign dma_end   = {end1, end0};
  assign dma_abort = abort_r;

  logic unused_bits;
  assign unused_bits = ^{PPROT, PADDR[APB_AW-1:8], ctrl_new[30:1],
                         num_new[30:29], num_new[27:24]};

endmodule

// File: tb/tb_mem2stream_apb_csr.sv
module tb_mem2stream_apb_csr;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, IRQ;
  logic        dma_en, dma_go, dma_cont, dma_abort, dma_done;
  logic [7:0]  dma_chunk;
  logic [15:0] dma_num;
  logic [63:0] dma_start, dma_end;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 PCLK = ~PCLK;

  mem2stream_apb_csr dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .IRQ(IRQ), .dma_en(dma_en), .dma_go(dma_go), .dma_cont(dma_cont),
    .dma_chunk(dma_chunk), .dma_num(dma_num), .dma_start(dma_start),
    .dma_end(dma_end), .dma_abort(dma_abort), .dma_done(dma_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the access-phase edge; PRDATA/PSLVERR sampled mid access phase.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic with_done,
                           output logic err, output logic [31:0] rd);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = be;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    dma_done = with_done;
    #1;
    err = PSLVERR;
    rd  = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; dma_done = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic e;
    logic [31:0] r;
    apb_write(a, d, 4'hF, 1'b0, e, r);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    d   = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge PCLK); #1;
    dma_done = 1'b1;
    @(posedge PCLK); #1;
    dma_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0; dma_done = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Reset state
    chk("rst_prdata", PRDATA, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_irq", IRQ, 0);
    chk("rst_abort", dma_abort, 0);
    chk("rst_go", dma_go, 0);
    chk("rst_en", dma_en, 0);
    chk("rst_start", dma_start, 0);
    chk("pready", PREADY, 1);

    // Map reads
    apb_read(32'h00, rd, er); chk("rd_version", rd, 32'h2019_0405); chk("rd_version_err", er, 0);
    apb_read(32'h10, rd, er); chk("rd_control", rd, 0);
    apb_read(32'h30, rd, er); chk("rd_num", rd, 0);
    apb_read(32'h40, rd, er); chk("rd_cnt", rd, 0);
    apb_read(32'h50, rd, er); chk("rd_bad_err", er, 1); chk("rd_bad_data", rd, 0);

    // GO with EN=0 is refused
    apb_write(32'h30, 32'h8000_0040, 4'hF, 1'b0, er, rd);
    chk("go_no_en_err", er, 1);
    chk("go_no_en_go", dma_go, 0);
    apb_read(32'h30, rd, er); chk("go_no_en_num", rd, 0);

    // Single job
    wr(32'h10, 32'h8000_0001);
    chk("en", dma_en, 1);
    wr(32'h20, 32'h0);
    wr(32'h28, 32'h400);
    chk("end_addr", dma_end, 64'h400);
    apb_write(32'h30, 32'h8010_0040, 4'hF, 1'b0, er, rd);
    chk("single_err", er, 0);
    chk("write_prdata_zero", rd, 0);
    chk("single_go", dma_go, 1);
    chk("single_chunk", dma_chunk, 8'h10);
    chk("single_num", dma_num, 16'h40);
    chk("single_cont", dma_cont, 0);
    chk("single_irq_pre", IRQ, 0);
    apb_write(32'h30, 32'h8020_0080, 4'hF, 1'b0, er, rd);
    chk("go_busy_err", er, 1);
    chk("go_busy_chunk", dma_chunk, 8'h10);
    pulse_done();
    chk("single_go_done", dma_go, 0);
    chk("single_irq", IRQ, 1);
    chk("single_abort", dma_abort, 0);
    apb_read(32'h30, rd, er); chk("single_num_rd", rd, 32'h0010_0040);
    apb_read(32'h10, rd, er); chk("single_ctrl_rd", rd, 32'h8000_0003);
    wr(32'h10, 32'h8000_0003);
    chk("w1c_irq", IRQ, 0);
    apb_read(32'h10, rd, er); chk("w1c_ctrl_rd", rd, 32'h8000_0001);

    // Continuous job, three passes
    wr(32'h40, 32'd3);
    wr(32'h30, 32'h9010_0020);
    chk("cont_go", dma_go, 1);
    chk("cont_flag", dma_cont, 1);
    pulse_done();
    apb_read(32'h40, rd, er); chk("cont_cnt2", rd, 2);
    chk("cont_go2", dma_go, 1);
    chk("cont_irq2", IRQ, 0);
    pulse_done();
    apb_read(32'h40, rd, er); chk("cont_cnt1", rd, 1);
    chk("cont_go1", dma_go, 1);
    pulse_done();
    chk("cont_go0", dma_go, 0);
    chk("cont_irq", IRQ, 1);
    apb_read(32'h40, rd, er); chk("cont_cnt0", rd, 0);
    apb_read(32'h10, rd, er); chk("cont_ip", rd, 32'h8000_0003);
    wr(32'h10, 32'h8000_0003);

    // Continuous with CNT=0 runs one pass
    wr(32'h30, 32'h9000_0010);
    apb_read(32'h40, rd, er); chk("cnt0_as1", rd, 1);
    pulse_done();
    chk("cnt0_go", dma_go, 0);
    chk("cnt0_irq", IRQ, 1);
    wr(32'h10, 32'h8000_0003);

    // Abort coincident with dma_done
    wr(32'h30, 32'h8010_0040);
    chk("abort_go_pre", dma_go, 1);
    apb_write(32'h30, 32'h0, 4'hF, 1'b1, er, rd);
    chk("abort_pulse", dma_abort, 1);
    chk("abort_go", dma_go, 0);
    chk("abort_irq", IRQ, 0);
    @(posedge PCLK); #1;
    chk("abort_single", dma_abort, 0);
    apb_read(32'h10, rd, er); chk("abort_no_ip", rd, 32'h8000_0001);

    // dma_done while idle is ignored
    pulse_done();
    chk("idle_done_irq", IRQ, 0);

    // Clearing EN mid-job
    wr(32'h30, 32'h8010_0040);
    wr(32'h10, 32'h0000_0001);
    chk("en_clr_abort", dma_abort, 1);
    chk("en_clr_go", dma_go, 0);
    @(posedge PCLK); #1;
    chk("en_clr_abort_end", dma_abort, 0);
    wr(32'h10, 32'h8000_0001);

    // Byte strobes
    apb_write(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, er, rd);
    chk("strb_start0", dma_start[31:0], 32'h00BB_00DD);

    // Upper address word
    apb_write(32'h24, 32'h1, 4'hF, 1'b0, er, rd);
    chk("start1_err", er, 0);
    apb_read(32'h24, rd, er);
`ifdef MEM2STREAM_CSR_ADDR64_EN
    chk("start1_rd", rd, 1);
    chk("start1_out", dma_start, 64'h1_00BB_00DD);
`else
    chk("start1_rd", rd, 0);
    chk("start1_out", dma_start, 64'h0_00BB_00DD);
`endif
    wr(32'h20, 32'h0);

    // Reset mid-job: GO clears, no abort pulse
    wr(32'h30, 32'h8010_0040);
    chk("rst_job_go_pre", dma_go, 1);
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    chk("rst_job_go", dma_go, 0);
    chk("rst_job_abort", dma_abort, 0);
    chk("rst_job_en", dma_en, 0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("rst_job_abort2", dma_abort, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
